// File: rtl/ps2_ram_arbiter_pkg.sv
// ps2_arb_pkg: shared constants and types for the PS2-to-RAM mailbox arbiter.
//   MBOX_ADDR_DEFAULT : default byte address of the mailbox word in data RAM
//   MBOX_VALID_BIT    : bit of the mailbox word that flags an unread byte
//   DROP_CNT_MAX      : saturation value of the overflow drop counter
//   mbox_word_t       : layout of the mailbox word as seen by the core
package ps2_arb_pkg;

    localparam logic [31:0] MBOX_ADDR_DEFAULT = 32'h0000_0400;
    localparam int          MBOX_VALID_BIT    = 8;
    localparam logic [7:0]  DROP_CNT_MAX      = 8'hFF;

    typedef struct packed {
        logic [22:0] pad;
        logic        valid;
        logic [7:0]  data;
    } mbox_word_t;

    // Build the word written into the mailbox when a byte is injected.
    function automatic mbox_word_t make_mbox_word(input logic [7:0] b);
        mbox_word_t w;
        w.pad   = '0;
        w.valid = 1'b1;
        w.data  = b;
        return w;
    endfunction

endpackage

// File: rtl/ps2_ram_arbiter_if.sv
// ps2_ram_arbiter_if: core-side request and RAM-side port of the shared
// data RAM write/address path.
//   cpu_we / cpu_re / cpu_addr / cpu_wdata : core request (driven by master)
//   ram_we / ram_addr / ram_wdata          : RAM port (driven by slave)
//
// Ownership rule: there is no ready signal back to the core. Whenever
// cpu_we or cpu_re is high the core owns the RAM port in that same cycle
// and the arbiter passes its signals through unchanged; the arbiter only
// drives the port itself in cycles where both strobes are low.
interface ps2_ram_arbiter_if;

    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;

    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wdata,
        input  ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wdata,
        output ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/ps2_ram_arbiter_byte_fifo.sv
// byte_fifo: synchronous 8-bit FIFO with a separate occupancy counter.
//   clk, reset : clock and synchronous active-low reset
//   push, din  : write request and byte; ignored when full unless popping
//   pop        : remove head; ignored when empty
//   head       : byte at the read pointer (valid when !empty)
//   count      : registered occupancy, 0..DEPTH
//   full/empty : decoded from count
// DEPTH must be a power of two (2..16) so the pointers wrap naturally.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // When full, a push is still accepted if a pop frees the slot in the
    // same cycle; the write lands on the slot being read out.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_ram_arbiter.sv
// ps2_ram_arbiter: shares the data RAM write/address port between the core
// and the PS2 receiver. Received bytes queue in a FIFO and are written into
// a mailbox word only in cycles where the core is not using memory.
//   clk, reset        : clock and synchronous active-low reset
//   bus (slave)       : core request in, RAM port out
//   ps2_rx_done_tick  : one-cycle strobe, ps2_rx_data valid
//   ps2_rx_data       : received byte
//   mbox_full         : mailbox holds a byte the core has not acknowledged
//   fifo_count        : queued bytes
//   drop_cnt          : saturating count of bytes lost to overflow
module ps2_ram_arbiter
    import ps2_arb_pkg::*;
#(
    parameter logic [31:0] MBOX_ADDR  = MBOX_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    ps2_ram_arbiter_if.slave              bus,
    input  logic                          ps2_rx_done_tick,
    input  logic [7:0]                    ps2_rx_data,
    output logic                          mbox_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_cnt
);

    logic       core_busy;
    logic       inject;
    logic       mbox_ack;
    logic       drop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    mbox_word_t inject_word;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ps2_rx_done_tick),
        .pop   (inject),
        .din   (ps2_rx_data),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The core always wins; injection only fills idle cycles and waits for
    // the previous byte to be acknowledged, so at most one write per ack.
    assign core_busy   = bus.cpu_we | bus.cpu_re;
    assign inject      = !core_busy && !mbox_full && !fifo_empty;
    assign mbox_ack    = bus.cpu_we && (bus.cpu_addr == MBOX_ADDR);
    assign drop        = ps2_rx_done_tick && fifo_full && !inject;
    assign inject_word = make_mbox_word(fifo_head);

    always_comb begin
        bus.ram_we    = bus.cpu_we;
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_wdata = bus.cpu_wdata;
        if (inject) begin
            bus.ram_we    = 1'b1;
            bus.ram_addr  = MBOX_ADDR;
            bus.ram_wdata = inject_word;
        end
    end

    // inject and mbox_ack are mutually exclusive (the ack is a core write),
    // so the order of these branches does not matter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mbox_full <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (mbox_ack) begin
                mbox_full <= bus.cpu_wdata[MBOX_VALID_BIT];
            end else if (inject) begin
                mbox_full <= 1'b1;
            end
            if (drop && (drop_cnt != DROP_CNT_MAX)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_ram_arbiter.sv
// tb_ps2_ram_arbiter: table-driven, directed and randomized checks of the
// mailbox arbiter against a queue-based reference model.
module tb_ps2_ram_arbiter;
    import ps2_arb_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] MBOX  = 32'h0000_0400;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       tick;
    logic [7:0] rx_data;
    logic       mbox_full;
    logic [2:0] fifo_count;
    logic [7:0] drop_cnt;

    ps2_ram_arbiter_if bus();

    ps2_ram_arbiter #(
        .MBOX_ADDR  (MBOX),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .ps2_rx_done_tick (tick),
        .ps2_rx_data      (rx_data),
        .mbox_full        (mbox_full),
        .fifo_count       (fifo_count),
        .drop_cnt         (drop_cnt)
    );

    // reference model: queued bytes, mailbox flag, drop count
    logic [7:0] exp_q[$];
    bit         m_full;
    int         m_drop;

    int checks = 0;
    int errors = 0;

    // values observed in the most recent step
    logic        obs_we;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic        obs_full;
    logic [2:0]  obs_cnt;
    logic [7:0]  obs_drop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // driver: apply one cycle of inputs, compare against the model, then
    // advance the model across the following rising edge
    task automatic step(input logic rst_n, input logic we, input logic re,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic tk, input logic [7:0] d);
        bit          m_inject;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        @(negedge clk);
        reset         = rst_n;
        bus.cpu_we    = we;
        bus.cpu_re    = re;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        tick          = tk;
        rx_data       = d;
        #1;
        obs_we    = bus.ram_we;
        obs_addr  = bus.ram_addr;
        obs_wdata = bus.ram_wdata;
        obs_full  = mbox_full;
        obs_cnt   = fifo_count;
        obs_drop  = drop_cnt;

        m_inject = !(we || re) && !m_full && (exp_q.size() != 0);
        e_we     = m_inject ? 1'b1 : we;
        e_addr   = m_inject ? MBOX : addr;
        e_wdata  = m_inject ? {23'b0, 1'b1, exp_q[0]} : wdata;
        check("ram_we", {31'b0, obs_we}, {31'b0, e_we});
        check("ram_addr", obs_addr, e_addr);
        check("ram_wdata", obs_wdata, e_wdata);
        check("mbox_full", {31'b0, obs_full}, {31'b0, m_full});
        check("fifo_count", {29'b0, obs_cnt}, exp_q.size());
        check("drop_cnt", {24'b0, obs_drop}, m_drop);

        if (!rst_n) begin
            exp_q.delete();
            m_full = 0;
            m_drop = 0;
        end else begin
            if (m_inject) begin
                void'(exp_q.pop_front());
                m_full = 1;
            end
            if (we && addr == MBOX) m_full = wdata[8];
            if (tk) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(d);
                else if (m_drop < 255) m_drop++;
            end
        end
    endtask

    task automatic idle(input logic tk, input logic [7:0] d);
        step(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, tk, d);
    endtask

    task automatic ack();
        step(1'b1, 1'b1, 1'b0, MBOX, 32'h0, 1'b0, 8'h00);
    endtask

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        tk;
        logic [7:0]  d;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_full;
        logic [2:0]  e_cnt;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vt[11];

    initial begin
        int         inj_seen;
        logic [7:0] got[4];
        logic [7:0] want[4];

        vt[0]  = '{0, 0, 32'h10,  32'hDEADBEEF, 1, 8'h1C, 0, 32'h10,  32'hDEADBEEF, 0, 3'd0, 8'd0};
        vt[1]  = '{0, 0, 32'h10,  32'hDEADBEEF, 1, 8'h32, 1, 32'h400, 32'h0000_011C, 0, 3'd1, 8'd0};
        vt[2]  = '{0, 0, 32'h10,  32'hDEADBEEF, 0, 8'h00, 0, 32'h10,  32'hDEADBEEF, 1, 3'd1, 8'd0};
        vt[3]  = '{0, 0, 32'h10,  32'hDEADBEEF, 0, 8'h00, 0, 32'h10,  32'hDEADBEEF, 1, 3'd1, 8'd0};
        vt[4]  = '{1, 0, 32'h400, 32'h0,        0, 8'h00, 1, 32'h400, 32'h0,         1, 3'd1, 8'd0};
        vt[5]  = '{0, 0, 32'h10,  32'hDEADBEEF, 0, 8'h00, 1, 32'h400, 32'h0000_0132, 0, 3'd1, 8'd0};
        vt[6]  = '{0, 0, 32'h10,  32'hDEADBEEF, 0, 8'h00, 0, 32'h10,  32'hDEADBEEF, 1, 3'd0, 8'd0};
        vt[7]  = '{0, 1, 32'h20,  32'h1234,     0, 8'h00, 0, 32'h20,  32'h1234,      1, 3'd0, 8'd0};
        vt[8]  = '{1, 0, 32'h44,  32'h55,       0, 8'h00, 1, 32'h44,  32'h55,        1, 3'd0, 8'd0};
        vt[9]  = '{1, 0, 32'h400, 32'h0,        0, 8'h00, 1, 32'h400, 32'h0,         1, 3'd0, 8'd0};
        vt[10] = '{0, 0, 32'h10,  32'hDEADBEEF, 0, 8'h00, 0, 32'h10,  32'hDEADBEEF, 0, 3'd0, 8'd0};

        reset = 1'b0;
        bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0;
        tick = 1'b0; rx_data = '0;
        m_full = 0; m_drop = 0;
        repeat (2) @(posedge clk);

        // table: single byte, second byte held until ack, pass-through rows
        for (int i = 0; i < 11; i++) begin
            step(1'b1, vt[i].we, vt[i].re, vt[i].addr, vt[i].wdata, vt[i].tk, vt[i].d);
            check($sformatf("tbl%0d_we", i), {31'b0, obs_we}, {31'b0, vt[i].e_we});
            check($sformatf("tbl%0d_addr", i), obs_addr, vt[i].e_addr);
            check($sformatf("tbl%0d_wdata", i), obs_wdata, vt[i].e_wdata);
            check($sformatf("tbl%0d_full", i), {31'b0, obs_full}, {31'b0, vt[i].e_full});
            check($sformatf("tbl%0d_cnt", i), {29'b0, obs_cnt}, {29'b0, vt[i].e_cnt});
            check($sformatf("tbl%0d_drop", i), {24'b0, obs_drop}, {24'b0, vt[i].e_drop});
        end

        // busy core with two bytes queued: no injection
        inj_seen = 0;
        step(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 8'hA1);
        step(1'b1, 1'b1, 1'b0, 32'h104, 32'h7, 1'b1, 8'hA2);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            a = {20'b0, 8'($urandom_range(0, 255)), 2'b00};
            step(1'b1, i[0], !i[0], a, $urandom, 1'b0, 8'h00);
            if (obs_addr == MBOX) inj_seen++;
        end
        check("busy_no_inject", inj_seen, 0);
        idle(1'b0, 8'h00);
        check("first_idle_we", {31'b0, obs_we}, 32'h1);
        check("first_idle_wdata", obs_wdata, 32'h0000_01A1);

        // overflow with mailbox held: 4 kept, 2 dropped
        ack();
        idle(1'b0, 8'h00);
        for (int i = 0; i < 6; i++) idle(1'b1, 8'h51 + 8'(i));
        idle(1'b0, 8'h00);
        check("ovf_count", {29'b0, obs_cnt}, 32'd4);
        check("ovf_drop", {24'b0, obs_drop}, 32'd2);

        // tick while full in the same cycle as the injection pop
        ack();
        idle(1'b1, 8'h60);
        check("pushpop_inject", obs_wdata, 32'h0000_0151);
        idle(1'b0, 8'h00);
        check("pushpop_count", {29'b0, obs_cnt}, 32'd4);
        check("pushpop_drop", {24'b0, obs_drop}, 32'd2);
        want[0] = 8'h52; want[1] = 8'h53; want[2] = 8'h54; want[3] = 8'h60;
        for (int i = 0; i < 4; i++) begin
            ack();
            idle(1'b0, 8'h00);
            got[i] = obs_wdata[7:0];
            check($sformatf("drain%0d", i), {24'b0, got[i]}, {24'b0, want[i]});
        end

        // drop counter saturation
        for (int i = 0; i < 300; i++) idle(1'b1, 8'($urandom));
        idle(1'b0, 8'h00);
        check("sat_drop", {24'b0, obs_drop}, 32'd255);
        check("sat_count", {29'b0, obs_cnt}, 32'd4);

        // reset mid-stream with 3 queued and mailbox full
        ack();
        idle(1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 8'h00);
        idle(1'b0, 8'h00);
        check("rst_count", {29'b0, obs_cnt}, 32'd0);
        check("rst_full", {31'b0, obs_full}, 32'd0);
        check("rst_drop", {24'b0, obs_drop}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0, 8'h00);
            check("rst_no_inject", {31'b0, obs_we}, 32'd0);
        end
        idle(1'b1, 8'h77);
        idle(1'b0, 8'h00);
        check("post_rst_inject", obs_wdata, 32'h0000_0177);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic        r_we;
            logic        r_re;
            logic [31:0] r_addr;
            r_we   = ($urandom_range(0, 3) == 0);
            r_re   = ($urandom_range(0, 3) == 0);
            r_addr = ($urandom_range(0, 5) == 0) ? MBOX : {20'b0, 10'($urandom_range(0, 1023)), 2'b00};
            step(($urandom_range(0, 199) != 0), r_we, r_re, r_addr, $urandom,
                 ($urandom_range(0, 2) == 0), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
